// File: rtl/sm_to_bcd_conv.sv
// Sign-magnitude to packed BCD converter: sequential double-dabble, one magnitude bit per clock.
// Optional leading-zero blank mask is enabled by defining CONV_BLANK_EN.
module sm_to_bcd_conv #(
    parameter int WIDTH  = 18,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      sm_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg_out,
    output logic [DIGITS-1:0]     blank_out
);

    localparam int CW = $clog2(WIDTH);
    localparam int SW = 4*DIGITS + WIDTH - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_next;
    logic [WIDTH-2:0]    mag, mag_shift;
    logic                sign;
    logic [4*DIGITS-1:0] bcd, bcd_adj, bcd_shift;
    logic [CW-1:0]       cnt;
    logic [SW-1:0]       shift_all;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Add-3 correction on every nibble before the shift so each digit carries properly.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        shift_all = {bcd_adj, mag} << 1;
        bcd_shift = shift_all[SW-1 -: 4*DIGITS];
        mag_shift = shift_all[WIDTH-2:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag     <= '0;
            sign    <= 1'b0;
            bcd     <= '0;
            cnt     <= '0;
            bcd_out <= '0;
            neg_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mag  <= sm_in[WIDTH-2:0];
                    sign <= sm_in[WIDTH-1];
                    bcd  <= '0;
                    cnt  <= CW'(WIDTH-1);
                end
                SHIFT: begin
                    bcd <= bcd_shift;
                    mag <= mag_shift;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd_out <= bcd_shift;
                        // A zero BCD result means zero magnitude: suppress "-0".
                        neg_out <= sign && (bcd_shift != '0);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CONV_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              zero_above;

    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int i = DIGITS-1; i >= 1; i--) begin
            zero_above    = zero_above && (bcd_shift[4*i +: 4] == 4'd0);
            blank_next[i] = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                 blank_out <= '0;
        else if (state == SHIFT && cnt == CW'(1)) blank_out <= blank_next;
    end
`else
    assign blank_out = '0;
`endif

endmodule

// File: doc/sm_to_bcd_conv.md
Name: sm_to_bcd_conv

Overview:
- Converts the calculator ALU's registered sign-magnitude result into packed BCD digits plus a minus flag for the 7-segment display path.
- Sits between the ALU result bus and the display multiplexer.
- Sequential double-dabble engine (shift/add-3): one magnitude bit per clock, start/busy/done handshake, outputs held between conversions.

Parameters:
- WIDTH, 18, total input width: bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude.
- DIGITS, 6, number of BCD output digits; must satisfy 10^DIGITS > 2^(WIDTH-1)-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- sm_in  input  WIDTH  sign-magnitude value; sampled on the accepting edge only.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse when bcd_out/neg_out update.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in bits 3:0.
- neg_out  output  1  display minus sign.
- blank_out  output  DIGITS  per-digit leading-zero blank mask; bit i = digit i.

Behaviour:
- One clock domain, single clock clk.
- Reset is synchronous, active-high (rst), on clk rising edge; it overrides all other activity, including a conversion in progress.
- Reset values: state=IDLE, busy=0, done=0, bcd_out=0, neg_out=0, blank_out=0, internal shift/BCD/counter registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - capture mag=sm_in[WIDTH-2:0] and sign=sm_in[WIDTH-1];
  - clear the BCD accumulator; load cnt=WIDTH-1; go to SHIFT.
- IDLE, start=0: hold state and all outputs.
- SHIFT, each edge:
  - every BCD nibble >=5 gets +3;
  - then {bcd,mag} shifts left by 1;
  - cnt decrements.
  - When the shift with cnt==1 completes (edge E0+WIDTH-1), go to DONE.
- DONE, on entry:
  - bcd_out and neg_out are registered on edge E0+WIDTH-1, and done=1 is driven during the DONE cycle.
  - Next edge returns to IDLE; done returns to 0.
- Latency: done is high in the cycle following edge E0+(WIDTH-1). For WIDTH=18: 17 edges after the start-sampling edge. busy is high for exactly WIDTH-1 cycles... plus the DONE cycle, i.e. WIDTH cycles total.
- start while busy=1 (SHIFT or DONE) is ignored, not queued. Earliest back-to-back start is the cycle after done.
- sm_in may change freely after the accepting edge; the conversion uses the captured value.
- Negative zero: sign=1 with magnitude=0 yields neg_out=0, bcd_out=0. The display never shows "-0".
- neg_out = sign AND (magnitude != 0).
- All unused high digits of bcd_out are 0. No overflow is possible given the DIGITS constraint.
- Reset mid-conversion:
  - all registers go to reset values on that edge;
  - no done pulse follows;
  - stale bcd_out is cleared to 0.
- Outputs are stable and held from one done pulse until the next done or reset.

Optional Feature:
- Macro: CONV_BLANK_EN
- When defined, blank_out is registered together with bcd_out in DONE:
  - bit i = 1 iff digit i and every more-significant digit are 0, for i >= 1;
  - bit 0 is always 0, so a value of zero still shows "0".
- When not defined, blank_out is tied to all zeros and no blanking logic is synthesized.
- Handshake timing is identical in both builds.

Test Plan:
1. Reset, then start with sm_in=18'h00000 -> done 17 cycles after the accepting edge; bcd_out=24'h000000; neg_out=0; busy high for exactly 18 cycles.
2. sm_in=18'h1FFFF (+131071) -> bcd_out=24'h131071; neg_out=0. With CONV_BLANK_EN: blank_out=6'b000000.
3. sm_in={1'b1,17'd12345} -> bcd_out=24'h012345; neg_out=1. With CONV_BLANK_EN: blank_out=6'b100000. Without it: blank_out=0.
4. sm_in={1'b1,17'd0} (negative zero) -> bcd_out=0; neg_out=0. With CONV_BLANK_EN: blank_out=6'b111110.
5. Start with 17'd999, then pulse start with 17'd5 at cycle 3 and in the DONE cycle -> both ignored; single done with bcd_out=24'h000999. Start in the following IDLE cycle -> bcd_out=24'h000005.
6. Convert 17'd4321, then start 17'd777 and assert rst at cycle 8 -> done never pulses; bcd_out=0, neg_out=0, busy=0 on the next cycle. A fresh start converts correctly.
